// File: rtl/uart_rx_engine_if.sv
// Receive-side handshake between uart_rx_engine and core logic.
//   master : engine side, drives rx_data/rx_rdy/perr/ferr/ovf (and brk), takes rx_read
//   slave  : consumer side, samples the byte and flags, pulses rx_read
// Optional feature macro: RX_BREAK_DETECT_EN adds the brk flag.
interface uart_rx_engine_if;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       perr;
  logic       ferr;
  logic       ovf;
  logic       rx_read;
`ifdef RX_BREAK_DETECT_EN
  logic       brk;

  modport master (output rx_data, rx_rdy, perr, ferr, ovf, brk, input rx_read);
  modport slave  (input rx_data, rx_rdy, perr, ferr, ovf, brk, output rx_read);
`else
  modport master (output rx_data, rx_rdy, perr, ferr, ovf, input rx_read);
  modport slave  (input rx_data, rx_rdy, perr, ferr, ovf, output rx_read);
`endif
endinterface

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronises rx, detects start, samples mid-bit, assembles 7/8 data
// bits plus optional parity, and presents the byte with ready/parity/framing/overflow flags.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   rx_i           serial input, idle high, LSB first
//   baud_i         rate select 0..11 (300..921600), 12..15 = 115200
//   eight_i        1 = 8 data bits, 0 = 7
//   p_en_i         parity bit present
//   ohel_i         parity sense, 1 = odd, 0 = even
//   bus_io         handshake to core logic (uart_rx_engine_if.master)
// Optional feature macro: RX_BREAK_DETECT_EN adds break detection (brk flag, BRK wait state).
module uart_rx_engine #(
  parameter int unsigned ClkHz = 100_000_000,
  parameter int unsigned CntW  = 20
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rx_i,
  input  logic [3:0]       baud_i,
  input  logic             eight_i,
  input  logic             p_en_i,
  input  logic             ohel_i,
  uart_rx_engine_if.master bus_io
);

`ifdef RX_BREAK_DETECT_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBrk} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e          state_q;
  logic            rx_meta_q, rxs_q;
  logic [CntW-1:0] cnt_q, k_q, k_sel;
  logic [3:0]      bit_cnt_q;
  logic [8:0]      shift_q;
  logic            eight_q, p_en_q, ohel_q;
  logic [7:0]      rx_data_q;
  logic            rx_rdy_q, perr_q, ferr_q, ovf_q;
`ifdef RX_BREAK_DETECT_EN
  logic            brk_q;
  logic            frame_zero;
`endif

  logic [3:0] n_bits;
  logic [8:0] aligned;
  logic [7:0] data_d;
  logic       pbit;
  logic       perr_d;
  logic       ovf_d;

  // Bit time per rate index; each branch folds to a constant.
  always_comb begin
    k_sel = CntW'(ClkHz / 115200);
    case (baud_i)
      4'd0:    k_sel = CntW'(ClkHz / 300);
      4'd1:    k_sel = CntW'(ClkHz / 1200);
      4'd2:    k_sel = CntW'(ClkHz / 2400);
      4'd3:    k_sel = CntW'(ClkHz / 4800);
      4'd4:    k_sel = CntW'(ClkHz / 9600);
      4'd5:    k_sel = CntW'(ClkHz / 19200);
      4'd6:    k_sel = CntW'(ClkHz / 38400);
      4'd7:    k_sel = CntW'(ClkHz / 57600);
      4'd8:    k_sel = CntW'(ClkHz / 115200);
      4'd9:    k_sel = CntW'(ClkHz / 230400);
      4'd10:   k_sel = CntW'(ClkHz / 460800);
      4'd11:   k_sel = CntW'(ClkHz / 921600);
      default: k_sel = CntW'(ClkHz / 115200);
    endcase
  end

  // Bits enter at the top of shift_q; after n shifts the frame sits in the top n bits.
  always_comb begin
    n_bits  = (eight_q ? 4'd8 : 4'd7) + {3'b000, p_en_q};
    aligned = shift_q >> (4'd9 - n_bits);
    data_d  = eight_q ? aligned[7:0] : {1'b0, aligned[6:0]};
    pbit    = eight_q ? aligned[8] : aligned[7];
    perr_d  = p_en_q & ((^data_d ^ pbit) != ohel_q);
    // Commit-cycle overflow: a read in the same cycle clears it.
    ovf_d   = bus_io.rx_read ? 1'b0 : (rx_rdy_q | ovf_q);
  end

`ifdef RX_BREAK_DETECT_EN
  assign frame_zero = (aligned == 9'd0) & ~rxs_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      cnt_q     <= '0;
      k_q       <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '1;
      eight_q   <= 1'b0;
      p_en_q    <= 1'b0;
      ohel_q    <= 1'b0;
      rx_data_q <= '0;
      rx_rdy_q  <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef RX_BREAK_DETECT_EN
      brk_q     <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx_i;
      rxs_q     <= rx_meta_q;

      // Consumer read; a commit later in this block overrides it.
      if (bus_io.rx_read) begin
        rx_rdy_q <= 1'b0;
        ovf_q    <= 1'b0;
`ifdef RX_BREAK_DETECT_EN
        brk_q    <= 1'b0;
`endif
      end

      case (state_q)
        StIdle: begin
          if (!rxs_q) begin
            state_q   <= StStart;
            k_q       <= k_sel;
            cnt_q     <= (k_sel >> 1) - CntW'(1);
            eight_q   <= eight_i;
            p_en_q    <= p_en_i;
            ohel_q    <= ohel_i;
            bit_cnt_q <= '0;
          end
        end
        StStart: begin
          if (cnt_q == '0) begin
            if (!rxs_q) begin
              state_q <= StData;
              cnt_q   <= k_q - CntW'(1);
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == '0) begin
            shift_q   <= {rxs_q, shift_q[8:1]};
            cnt_q     <= k_q - CntW'(1);
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == n_bits - 4'd1) state_q <= StStop;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StStop: begin
          if (cnt_q == '0) begin
            rx_data_q <= data_d;
            perr_q    <= perr_d;
            ferr_q    <= ~rxs_q;
            rx_rdy_q  <= 1'b1;
            ovf_q     <= ovf_d;
`ifdef RX_BREAK_DETECT_EN
            brk_q     <= frame_zero;
            state_q   <= frame_zero ? StBrk : StIdle;
`else
            state_q   <= StIdle;
`endif
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
`ifdef RX_BREAK_DETECT_EN
        StBrk: begin
          // Hold off re-arming until the line returns to idle.
          if (rxs_q) state_q <= StIdle;
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.rx_data = rx_data_q;
  assign bus_io.rx_rdy  = rx_rdy_q;
  assign bus_io.perr    = perr_q;
  assign bus_io.ferr    = ferr_q;
  assign bus_io.ovf     = ovf_q;
`ifdef RX_BREAK_DETECT_EN
  assign bus_io.brk     = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_engine.sv
module tb_uart_rx_engine;
  localparam int unsigned ClkHz = 1_000_000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [3:0] baud;
  logic       eight, p_en, ohel;

  uart_rx_engine_if u_if ();

  uart_rx_engine #(
    .ClkHz(ClkHz),
    .CntW (20)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .rx_i   (rx),
    .baud_i (baud),
    .eight_i(eight),
    .p_en_i (p_en),
    .ohel_i (ohel),
    .bus_io (u_if.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int start_cyc = 0;
  int rise_cyc  = 0;
  logic rdy_prev = 1'b0;
  bit check_en = 1'b0;

  // Expected state of the consumer-visible outputs.
  logic [7:0] m_data;
  logic       m_rdy, m_perr, m_ferr, m_ovf;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (u_if.rx_rdy && !rdy_prev) rise_cyc = cyc;
    rdy_prev = u_if.rx_rdy;
  end

  // Whole-bundle comparison on every cycle the outputs are settled.
  always @(negedge clk) begin
    if (check_en) begin
      checks++;
      if ({u_if.rx_rdy, u_if.rx_data, u_if.perr, u_if.ferr, u_if.ovf} !==
          {m_rdy, m_data, m_perr, m_ferr, m_ovf}) begin
        fails++;
        $display("FAIL model_cmp t=%0t actual rdy=%b data=%h perr=%b ferr=%b ovf=%b required rdy=%b data=%h perr=%b ferr=%b ovf=%b",
                 $time, u_if.rx_rdy, u_if.rx_data, u_if.perr, u_if.ferr, u_if.ovf,
                 m_rdy, m_data, m_perr, m_ferr, m_ovf);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int unsigned bit_clocks(input logic [3:0] b);
    int unsigned rates[12] = '{300, 1200, 2400, 4800, 9600, 19200, 38400, 57600,
                               115200, 230400, 460800, 921600};
    if (b < 4'd12) return ClkHz / rates[b];
    return ClkHz / 115200;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame, then one idle bit, then applies the frame to the model.
  task automatic send_frame(input logic [7:0] d, input int nb, input bit par, input bit pb,
                            input bit stop);
    int k;
    logic [7:0] dd;
    k = int'(bit_clocks(baud));
    check_en = 1'b0;
    @(posedge clk);
    #1;
    rx = 1'b0;
    start_cyc = cyc;
    wait_clks(k);
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      wait_clks(k);
    end
    if (par) begin
      rx = pb;
      wait_clks(k);
    end
    rx = stop;
    wait_clks(k);
    rx = 1'b1;
    wait_clks(k);
    dd = (nb == 8) ? d : {1'b0, d[6:0]};
    m_ovf  = m_rdy ? 1'b1 : m_ovf;
    m_rdy  = 1'b1;
    m_data = dd;
    m_perr = par && ((^dd ^ pb) != ohel);
    m_ferr = !stop;
    check_en = 1'b1;
  endtask

  task automatic do_read();
    @(negedge clk);
    check_en = 1'b0;
    u_if.rx_read = 1'b1;
    @(posedge clk);
    #1;
    u_if.rx_read = 1'b0;
    m_rdy = 1'b0;
    m_ovf = 1'b0;
    check_en = 1'b1;
  endtask

  task automatic check_latency(input string name, input int n, input int k);
    int lat, lo, hi;
    lat = rise_cyc - start_cyc;
    lo  = ((2 * n + 3) * k) / 2;
    hi  = lo + 6;
    checks++;
    if (lat < lo || lat > hi) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, lat, lo, hi);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog run did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    baud = 4'd4;
    eight = 1'b1;
    p_en = 1'b0;
    ohel = 1'b0;
    u_if.rx_read = 1'b0;
    m_data = 8'h00; m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    check_en = 1'b1;
    wait_clks(5);
    check("reset_outputs", {23'd0, u_if.rx_rdy, u_if.rx_data, u_if.perr, u_if.ferr, u_if.ovf}, 32'd0);
    rst_n = 1'b1;
    wait_clks(5);

    // 1: 8N1 0xA5 at 9600
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    check("t1_data", u_if.rx_data, 8'hA5);
    check("t1_rdy", u_if.rx_rdy, 1);
    check("t1_flags", {u_if.perr, u_if.ferr, u_if.ovf}, 0);
    check_latency("t1_latency", 8, 104);
    do_read();
    check("t1_rdy_clr", u_if.rx_rdy, 0);

    // 2: 7E1 0x41 with wrong parity bit at 115200
    baud = 4'd8; eight = 1'b0; p_en = 1'b1; ohel = 1'b0;
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
    check("t2_data", u_if.rx_data, 8'h41);
    check("t2_perr", u_if.perr, 1);
    check_latency("t2_latency", 8, 8);
    do_read();

    // 8O1 0x03 with correct odd parity
    eight = 1'b1; ohel = 1'b1;
    send_frame(8'h03, 8, 1'b1, 1'b1, 1'b1);
    check("t2b_perr", u_if.perr, 0);
    check("t2b_data", u_if.rx_data, 8'h03);
    do_read();

    // 3: framing error
    baud = 4'd4; eight = 1'b1; p_en = 1'b0; ohel = 1'b0;
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
    check("t3_data", u_if.rx_data, 8'h3C);
    check("t3_ferr", u_if.ferr, 1);
    check("t3_rdy", u_if.rx_rdy, 1);
    do_read();

    // 4: glitch of k/4 clocks is a false start
    rx = 1'b0;
    wait_clks(26);
    rx = 1'b1;
    wait_clks(3 * 104);
    check("t4_no_rdy", u_if.rx_rdy, 0);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    check("t4_rearm_data", u_if.rx_data, 8'h5A);
    do_read();

    // 5: overflow
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
    check("t5_data", u_if.rx_data, 8'h22);
    check("t5_ovf", u_if.ovf, 1);
    do_read();
    check("t5_ovf_clr", u_if.ovf, 0);
    check("t5_rdy_clr", u_if.rx_rdy, 0);

    // 6: reset mid-frame with a pending byte, then a clean frame
    send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1);
    check_en = 1'b0;
    rx = 1'b0;
    wait_clks(104);
    rx = 1'b1;
    wait_clks(104);
    rx = 1'b0;
    wait_clks(52);
    rst_n = 1'b0;
    rx = 1'b1;
    m_data = 8'h00; m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    check_en = 1'b1;
    wait_clks(5);
    check("t6_reset_data", u_if.rx_data, 8'h00);
    check("t6_reset_rdy", u_if.rx_rdy, 0);
    rst_n = 1'b1;
    wait_clks(10);
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1);
    check("t6_data", u_if.rx_data, 8'h0F);
    check("t6_rdy", u_if.rx_rdy, 1);
    wait_clks(4);

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
